// File: rtl/pitch_fr3_ctrl_pkg.sv
// pitch_fr3_ctrl_pkg
// Shared constants, state encoding and window-check helper for the
// fractional-pitch open-window search sequencer (pitch_fr3_ctrl).
//   L_INTER4         : half-width of the interpolation guard band added to the window
//   MAX_LAG_SPAN     : largest accepted t0_max - t0_min
//   PITCH_FR3_CORR_V : scratch-memory base of the normalized-correlation vector
//   CORR_FLOOR       : most negative Q31 value, reported for a rejected window
package pitch_fr3_ctrl_pkg;

    localparam int          L_INTER4         = 4;
    localparam int          MAX_LAG_SPAN     = 31;
    localparam logic [11:0] PITCH_FR3_CORR_V = 12'hFF0;
    localparam logic [31:0] CORR_FLOOR       = 32'h8000_0000;

    typedef enum logic [2:0] {
        PFC_IDLE,
        PFC_LAUNCH,
        PFC_WAIT_NC,
        PFC_SCAN,
        PFC_DRAIN,
        PFC_FINISH
    } pfc_state_t;

    // The span is formed at 17 bits so extreme signed bounds cannot wrap
    // into an apparently valid window.
    function automatic logic windowInvalid(input logic [15:0] tMin, input logic [15:0] tMax);
        logic signed [16:0] span;
        span = $signed({tMax[15], tMax}) - $signed({tMin[15], tMin});
        return (span < 17'sd0) || (span > $signed(17'(MAX_LAG_SPAN)));
    endfunction

endpackage

// File: rtl/pitch_fr3_ctrl_argmax.sv
// pitch_lag_argmax
// Running signed maximum with the index where it was found. A sample equal
// to the current maximum replaces it, so ties resolve to the later (larger)
// index. A valid sample with i_clear set is loaded unconditionally.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_clear    : first sample of a new search
//   i_valid    : i_data / i_index carry a sample this cycle
//   i_data     : signed 32-bit sample
//   i_index    : index tagged to the sample
//   o_max      : current maximum
//   o_index    : index of o_max
module pitch_lag_argmax (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic [15:0] i_index,
    output logic [31:0] o_max,
    output logic [15:0] o_index
);

    logic [31:0] r_max;
    logic [15:0] r_index;

    // Capture a sample when it starts a search or is at least the current maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max   <= '0;
            r_index <= '0;
        end else if (i_valid && (i_clear || ($signed(i_data) >= $signed(r_max)))) begin
            r_max   <= i_data;
            r_index <= i_index;
        end
    end

    assign o_max   = r_max;
    assign o_index = r_index;

endmodule

// File: rtl/pitch_fr3_ctrl.sv
// pitch_fr3_ctrl
// Sequences the fractional-pitch open-window search: widens the integer lag
// window by L_INTER4, launches the normalized-correlation datapath, then takes
// the scratch memory back and scans the correlation vector for the integer
// lag with the largest correlation.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   start                : one-cycle pulse, accepted only when idle
//   t0_min, t0_max       : signed integer lag window
//   excAddr              : past-excitation base for this subframe
//   normCorrDone         : completion pulse from the datapath
//   normCorrStart        : one-cycle launch pulse to the datapath
//   normCorrTMin/TMax    : widened window handed to the datapath
//   normCorrExcAddr      : latched excAddr
//   normCorrMuxSel       : scratch-memory owner, 0 = datapath, 1 = this block
//   memReadAddr, memIn   : scratch-memory read port (one cycle latency)
//   lag, maxCorr, err    : result, held until the next accepted start
//   done                 : one-cycle completion pulse
module pitch_fr3_ctrl
    import pitch_fr3_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] t0_min,
    input  logic [15:0] t0_max,
    input  logic [11:0] excAddr,
    input  logic        normCorrDone,
    output logic        normCorrStart,
    output logic [15:0] normCorrTMin,
    output logic [15:0] normCorrTMax,
    output logic [11:0] normCorrExcAddr,
    output logic        normCorrMuxSel,
    output logic [11:0] memReadAddr,
    input  logic [31:0] memIn,
    output logic [15:0] lag,
    output logic [31:0] maxCorr,
    output logic        err,
    output logic        done
);

    pfc_state_t  r_state;
    pfc_state_t  w_nextState;

    logic        w_startAccept;
    logic        w_invalid;
    logic        w_invalidStart;
    logic        w_scanLast;
    logic [4:0]  w_spanLow;

    logic [15:0] r_t0Min;
    logic [15:0] r_ncTMin;
    logic [15:0] r_ncTMax;
    logic [11:0] r_excAddr;
    logic [11:0] r_addr;
    logic [4:0]  r_span;
    logic [4:0]  r_k;
    logic [4:0]  r_rdK;
    logic        r_rdValid;
    logic        r_err;

    logic        w_amClear;
    logic        w_amValid;
    logic [31:0] w_amData;
    logic [15:0] w_amIndex;

    assign w_startAccept  = start && (r_state == PFC_IDLE);
    assign w_invalid      = windowInvalid(t0_min, t0_max);
    assign w_invalidStart = w_startAccept && w_invalid;
    // Only a validated span (0..31) is ever stored, so the low five bits suffice.
    assign w_spanLow      = t0_max[4:0] - t0_min[4:0];
    assign w_scanLast     = (r_k == r_span);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PFC_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A rejected window detours through DRAIN so its done
    // pulse lands two cycles after start without ever launching the datapath.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            PFC_IDLE:    if (start) w_nextState = w_invalid ? PFC_DRAIN : PFC_LAUNCH;
            PFC_LAUNCH:  w_nextState = PFC_WAIT_NC;
            PFC_WAIT_NC: if (normCorrDone) w_nextState = PFC_SCAN;
            PFC_SCAN:    if (w_scanLast) w_nextState = PFC_DRAIN;
            PFC_DRAIN:   w_nextState = PFC_FINISH;
            PFC_FINISH:  w_nextState = PFC_IDLE;
            default:     w_nextState = PFC_IDLE;
        endcase
    end

    // Moore outputs. The datapath owns the memory from LAUNCH until the
    // cycle its done pulse is sampled; this block owns it otherwise.
    always_comb begin
        normCorrStart  = (r_state == PFC_LAUNCH);
        normCorrMuxSel = !((r_state == PFC_LAUNCH) || (r_state == PFC_WAIT_NC));
        done           = (r_state == PFC_FINISH);
    end

    // Window latch, scan address counter and the read-tag pipeline that lines
    // each returning memIn word up with its k.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_t0Min   <= '0;
            r_ncTMin  <= '0;
            r_ncTMax  <= '0;
            r_excAddr <= '0;
            r_span    <= '0;
            r_err     <= 1'b0;
            r_k       <= '0;
            r_addr    <= '0;
            r_rdValid <= 1'b0;
            r_rdK     <= '0;
        end else begin
            if (w_startAccept) begin
                r_t0Min   <= t0_min;
                r_ncTMin  <= t0_min - 16'(L_INTER4);
                r_ncTMax  <= t0_max + 16'(L_INTER4);
                r_excAddr <= excAddr;
                r_span    <= w_spanLow;
                r_err     <= w_invalid;
            end
            if ((r_state == PFC_WAIT_NC) && normCorrDone) begin
                r_k    <= '0;
                r_addr <= PITCH_FR3_CORR_V + 12'(L_INTER4);
            end else if ((r_state == PFC_SCAN) && !w_scanLast) begin
                r_k    <= r_k + 5'd1;
                r_addr <= r_addr + 12'd1;
            end
            r_rdValid <= (r_state == PFC_SCAN);
            r_rdK     <= r_k;
        end
    end

    // A rejected window is written straight into the argmax as a cleared
    // sample, so lag/maxCorr always come from the same registers.
    assign w_amClear = w_invalidStart || (r_rdK == 5'd0);
    assign w_amValid = w_invalidStart || r_rdValid;
    assign w_amData  = w_invalidStart ? CORR_FLOOR : memIn;
    assign w_amIndex = w_invalidStart ? t0_min : (r_t0Min + {11'd0, r_rdK});

    pitch_lag_argmax u_argmax (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_amClear),
        .i_valid (w_amValid),
        .i_data  (w_amData),
        .i_index (w_amIndex),
        .o_max   (maxCorr),
        .o_index (lag)
    );

    assign normCorrTMin    = r_ncTMin;
    assign normCorrTMax    = r_ncTMax;
    assign normCorrExcAddr = r_excAddr;
    assign memReadAddr     = r_addr;
    assign err             = r_err;

endmodule

// File: tb/tb_pitch_fr3_ctrl.sv
// tb_pitch_fr3_ctrl
// Self-checking bench for pitch_fr3_ctrl. A scratch-memory model with one
// cycle of read latency feeds memIn; the normalized-correlation datapath is
// mimicked by a done pulse after a chosen latency. Expected results come
// from a plain argmax over the correlation values written into memory.
module tb_pitch_fr3_ctrl;
    import pitch_fr3_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] t0_min;
    logic [15:0] t0_max;
    logic [11:0] excAddr;
    logic        normCorrDone;
    logic        normCorrStart;
    logic [15:0] normCorrTMin;
    logic [15:0] normCorrTMax;
    logic [11:0] normCorrExcAddr;
    logic        normCorrMuxSel;
    logic [11:0] memReadAddr;
    logic [31:0] memIn;
    logic [15:0] lag;
    logic [31:0] maxCorr;
    logic        err;
    logic        done;

    int checks = 0;
    int passes = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] vals [$];

    // Observations recorded by drive_search; rel counts cycles after start's edge.
    int          obsStartCnt;
    int          obsStartRel;
    int          obsMuxBad;
    int          obsDoneRel;
    logic        obsDoneAfter;
    logic [15:0] obsLag;
    logic [31:0] obsMax;
    logic        obsErr;
    logic [15:0] obsTMin;
    logic [15:0] obsTMax;
    logic [11:0] obsExc;
    logic [11:0] addrQ [$];
    int          lastDRel;
    int          lastSpan;
    bit          lastValid;

    pitch_fr3_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .t0_min          (t0_min),
        .t0_max          (t0_max),
        .excAddr         (excAddr),
        .normCorrDone    (normCorrDone),
        .normCorrStart   (normCorrStart),
        .normCorrTMin    (normCorrTMin),
        .normCorrTMax    (normCorrTMax),
        .normCorrExcAddr (normCorrExcAddr),
        .normCorrMuxSel  (normCorrMuxSel),
        .memReadAddr     (memReadAddr),
        .memIn           (memIn),
        .lag             (lag),
        .maxCorr         (maxCorr),
        .err             (err),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratch memory: data appears one cycle after the address.
    always @(posedge clk) memIn <= mem[memReadAddr];

    function automatic logic [11:0] corr_addr(input int k);
        return 12'((int'(PITCH_FR3_CORR_V) + L_INTER4 + k) % 4096);
    endfunction

    // Reference: validate the window, then take the last position holding the largest value.
    function automatic void ref_search(input logic [15:0] tmin, input logic [15:0] tmax,
                                       output logic [15:0] eLag, output logic [31:0] eMax,
                                       output logic eErr);
        int lo, hi, span, best;
        lo   = int'($signed(tmin));
        hi   = int'($signed(tmax));
        span = hi - lo;
        if (span < 0 || span > MAX_LAG_SPAN) begin
            eErr = 1'b1;
            eLag = tmin;
            eMax = 32'h8000_0000;
        end else begin
            best = 0;
            for (int k = 1; k <= span; k++)
                if ($signed(vals[k]) >= $signed(vals[best])) best = k;
            eErr = 1'b0;
            eLag = 16'(lo + best);
            eMax = vals[best];
        end
    endfunction

    function automatic int addr_errors(input int span);
        int n;
        n = 0;
        if (addrQ.size() != span + 1) return span + 1;
        for (int k = 0; k <= span; k++)
            if (addrQ[k] !== corr_addr(k)) n++;
        return n;
    endfunction

    task automatic load_corr();
        foreach (vals[k]) mem[corr_addr(k)] = vals[k];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one search (mimicking the datapath) and records what the DUT shows.
    task automatic drive_search(input logic [15:0] tmin, input logic [15:0] tmax,
                                input logic [11:0] exc, input int ncLat, input int restartRel);
        int  lo, hi;
        bit  finished;
        logic expMux;
        lo        = int'($signed(tmin));
        hi        = int'($signed(tmax));
        lastSpan  = hi - lo;
        lastValid = (lastSpan >= 0) && (lastSpan <= MAX_LAG_SPAN);
        lastDRel  = 2 + ncLat;
        obsStartCnt = 0; obsStartRel = -1; obsMuxBad = 0; obsDoneRel = -1;
        obsDoneAfter = 1'bx;
        addrQ.delete();
        finished = 0;
        start = 1'b1; t0_min = tmin; t0_max = tmax; excAddr = exc;
        for (int rel = 1; rel <= 200 && !finished; rel++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            normCorrDone = 1'b0;
            if (rel == 1) begin
                obsTMin = normCorrTMin; obsTMax = normCorrTMax; obsExc = normCorrExcAddr;
            end
            if (normCorrStart === 1'b1) begin
                obsStartCnt++;
                obsStartRel = rel;
            end
            expMux = (lastValid && rel <= lastDRel) ? 1'b0 : 1'b1;
            if (normCorrMuxSel !== expMux) obsMuxBad++;
            if (lastValid && rel > lastDRel && rel <= lastDRel + 1 + lastSpan)
                addrQ.push_back(memReadAddr);
            if (done === 1'b1) begin
                obsDoneRel = rel; obsLag = lag; obsMax = maxCorr; obsErr = err;
                finished = 1;
            end
            if (lastValid && rel == lastDRel) normCorrDone = 1'b1;
            if (rel == restartRel) begin
                start = 1'b1; t0_min = 16'd100; t0_max = 16'd90;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        obsDoneAfter = done;
    endtask

    task automatic test_reset();
        checks++;
        if ({normCorrStart, normCorrMuxSel, memReadAddr, lag, maxCorr, err, done,
             normCorrTMin, normCorrTMax, normCorrExcAddr} !==
            {1'b0, 1'b1, 12'd0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 16'd0, 12'd0})
            $display("[TB] FAIL reset_values: got start=%b mux=%b addr=%h lag=%h max=%h err=%b done=%b tmin=%h tmax=%h exc=%h required 0/1/0...",
                     normCorrStart, normCorrMuxSel, memReadAddr, lag, maxCorr, err, done,
                     normCorrTMin, normCorrTMax, normCorrExcAddr);
        else passes++;
    endtask

    task automatic test_peak_window();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals = {32'h1000, 32'h1800, 32'h2000, 32'h2800, 32'h3000,
                32'h3A00, 32'h3000, 32'h2000, 32'h1000, 32'h0800};
        load_corr();
        ref_search(16'd40, 16'd49, eLag, eMax, eErr);
        drive_search(16'd40, 16'd49, 12'h155, 2, 0);
        checks++; if (obsTMin !== 16'(40 - L_INTER4)) $display("[TB] FAIL peak_tmin: got %0d required %0d", obsTMin, 40 - L_INTER4); else passes++;
        checks++; if (obsTMax !== 16'(49 + L_INTER4)) $display("[TB] FAIL peak_tmax: got %0d required %0d", obsTMax, 49 + L_INTER4); else passes++;
        checks++; if (obsExc !== 12'h155) $display("[TB] FAIL peak_exc: got %h required 155", obsExc); else passes++;
        checks++; if (obsStartCnt != 1 || obsStartRel != 1) $display("[TB] FAIL peak_ncstart: got count %0d at %0d required 1 at 1", obsStartCnt, obsStartRel); else passes++;
        checks++; if (obsMuxBad != 0) $display("[TB] FAIL peak_mux: got %0d bad cycles required 0", obsMuxBad); else passes++;
        checks++; if (addr_errors(lastSpan) != 0) $display("[TB] FAIL peak_addr: got %0d bad addresses required 0", addr_errors(lastSpan)); else passes++;
        checks++; if (obsDoneRel != lastDRel + 3 + lastSpan) $display("[TB] FAIL peak_done_time: got %0d required %0d", obsDoneRel, lastDRel + 3 + lastSpan); else passes++;
        checks++; if (obsLag !== eLag) $display("[TB] FAIL peak_lag: got %0d required %0d", obsLag, eLag); else passes++;
        checks++; if (obsMax !== eMax) $display("[TB] FAIL peak_max: got %h required %h", obsMax, eMax); else passes++;
        checks++; if (obsErr !== eErr) $display("[TB] FAIL peak_err: got %b required %b", obsErr, eErr); else passes++;
        checks++; if (obsDoneAfter !== 1'b0) $display("[TB] FAIL peak_done_width: got %b required 0", obsDoneAfter); else passes++;
        idle(2);
        checks++; if (lag !== eLag || maxCorr !== eMax) $display("[TB] FAIL peak_hold: got %0d/%h required %0d/%h", lag, maxCorr, eLag, eMax); else passes++;
    endtask

    task automatic test_tie();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals = {32'h0400, 32'h0800, 32'h1000, 32'h0C00, 32'h0FFF,
                32'h0200, 32'h0800, 32'h1000, 32'h0900, 32'h0100};
        load_corr();
        ref_search(16'd20, 16'd29, eLag, eMax, eErr);
        drive_search(16'd20, 16'd29, 12'h020, 0, 0);
        checks++; if (obsLag !== eLag) $display("[TB] FAIL tie_lag: got %0d required %0d", obsLag, eLag); else passes++;
        checks++; if (obsMax !== eMax) $display("[TB] FAIL tie_max: got %h required %h", obsMax, eMax); else passes++;
        idle(1);
    endtask

    task automatic test_negative_single();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals = {32'hFFFF_F000};
        load_corr();
        ref_search(16'd143, 16'd143, eLag, eMax, eErr);
        drive_search(16'd143, 16'd143, 12'h300, 3, 0);
        checks++; if (obsLag !== eLag || obsMax !== eMax) $display("[TB] FAIL neg_result: got %0d/%h required %0d/%h", obsLag, obsMax, eLag, eMax); else passes++;
        checks++; if (addrQ.size() != 1 || addr_errors(0) != 0) $display("[TB] FAIL neg_single_read: got %0d reads first %h required 1 at %h", addrQ.size(), (addrQ.size() > 0) ? addrQ[0] : 12'h000, corr_addr(0)); else passes++;
        checks++; if (obsDoneRel != lastDRel + 3) $display("[TB] FAIL neg_done_time: got %0d required %0d", obsDoneRel, lastDRel + 3); else passes++;
        idle(1);
    endtask

    task automatic test_invalid_window();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        logic [15:0] tMinList [3];
        logic [15:0] tMaxList [3];
        tMinList = '{16'd40, 16'd10, 16'hFFF0};
        tMaxList = '{16'd30, 16'd42, 16'hFFEF};
        for (int i = 0; i < 3; i++) begin
            vals.delete();
            ref_search(tMinList[i], tMaxList[i], eLag, eMax, eErr);
            drive_search(tMinList[i], tMaxList[i], 12'h0AB, 0, 0);
            checks++; if (obsStartCnt != 0) $display("[TB] FAIL inv%0d_ncstart: got %0d pulses required 0", i, obsStartCnt); else passes++;
            checks++; if (obsDoneRel != 2) $display("[TB] FAIL inv%0d_done_time: got %0d required 2", i, obsDoneRel); else passes++;
            checks++; if (obsErr !== eErr || obsLag !== eLag || obsMax !== eMax) $display("[TB] FAIL inv%0d_result: got err=%b lag=%0d max=%h required err=%b lag=%0d max=%h", i, obsErr, obsLag, obsMax, eErr, eLag, eMax); else passes++;
            checks++; if (obsMuxBad != 0) $display("[TB] FAIL inv%0d_mux: got %0d bad cycles required 0", i, obsMuxBad); else passes++;
            idle(1);
        end
    endtask

    task automatic test_span_boundary();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals.delete();
        for (int k = 0; k <= 31; k++) vals.push_back($urandom());
        load_corr();
        ref_search(16'd100, 16'd131, eLag, eMax, eErr);
        drive_search(16'd100, 16'd131, 12'h7FF, 1, 0);
        checks++; if (obsErr !== 1'b0 || obsLag !== eLag || obsMax !== eMax) $display("[TB] FAIL span31_result: got err=%b lag=%0d max=%h required err=0 lag=%0d max=%h", obsErr, obsLag, obsMax, eLag, eMax); else passes++;
        checks++; if (addr_errors(31) != 0) $display("[TB] FAIL span31_addr: got %0d bad addresses required 0", addr_errors(31)); else passes++;
        checks++; if (obsDoneRel != lastDRel + 34) $display("[TB] FAIL span31_done_time: got %0d required %0d", obsDoneRel, lastDRel + 34); else passes++;
        idle(1);
    endtask

    task automatic test_reset_in_wait();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals = {32'h0000_0100, 32'h0000_0500, 32'h0000_0300};
        load_corr();
        start = 1'b1; t0_min = 16'd60; t0_max = 16'd62; excAddr = 12'h444;
        idle(1);
        start = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checks++;
        if ({normCorrStart, normCorrMuxSel, memReadAddr, lag, maxCorr, err, done,
             normCorrTMin, normCorrTMax, normCorrExcAddr} !==
            {1'b0, 1'b1, 12'd0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 16'd0, 12'd0})
            $display("[TB] FAIL wait_reset_values: got start=%b mux=%b addr=%h lag=%h max=%h err=%b done=%b tmin=%h tmax=%h exc=%h required 0/1/0...",
                     normCorrStart, normCorrMuxSel, memReadAddr, lag, maxCorr, err, done,
                     normCorrTMin, normCorrTMax, normCorrExcAddr);
        else passes++;
        normCorrDone = 1'b1;
        idle(1);
        normCorrDone = 1'b0;
        idle(4);
        checks++; if (done !== 1'b0 || normCorrMuxSel !== 1'b1 || memReadAddr !== 12'd0) $display("[TB] FAIL wait_reset_idle: got done=%b mux=%b addr=%h required 0/1/000", done, normCorrMuxSel, memReadAddr); else passes++;
        ref_search(16'd60, 16'd62, eLag, eMax, eErr);
        drive_search(16'd60, 16'd62, 12'h444, 4, 0);
        checks++; if (obsLag !== eLag || obsMax !== eMax || obsErr !== eErr) $display("[TB] FAIL wait_reset_rerun: got %0d/%h/%b required %0d/%h/%b", obsLag, obsMax, obsErr, eLag, eMax, eErr); else passes++;
        checks++; if (obsDoneRel != lastDRel + 3 + lastSpan) $display("[TB] FAIL wait_reset_done_time: got %0d required %0d", obsDoneRel, lastDRel + 3 + lastSpan); else passes++;
        idle(1);
    endtask

    task automatic test_start_during_scan();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        vals = {32'h0000_0010, 32'h7FFF_0000, 32'h8000_0001, 32'h0000_0020,
                32'h0000_0030, 32'h0000_0040, 32'h0000_0050, 32'h0000_0060,
                32'h0000_0070, 32'h0000_0080};
        load_corr();
        ref_search(16'd70, 16'd79, eLag, eMax, eErr);
        drive_search(16'd70, 16'd79, 12'h0F0, 5, 7 + 3);
        checks++; if (obsLag !== eLag || obsMax !== eMax || obsErr !== eErr) $display("[TB] FAIL restart_result: got %0d/%h/%b required %0d/%h/%b", obsLag, obsMax, obsErr, eLag, eMax, eErr); else passes++;
        checks++; if (obsStartCnt != 1 || obsMuxBad != 0) $display("[TB] FAIL restart_launch: got pulses=%0d badmux=%0d required 1/0", obsStartCnt, obsMuxBad); else passes++;
        checks++; if (normCorrTMin !== 16'(70 - L_INTER4) || normCorrTMax !== 16'(79 + L_INTER4)) $display("[TB] FAIL restart_window: got %0d/%0d required %0d/%0d", normCorrTMin, normCorrTMax, 70 - L_INTER4, 79 + L_INTER4); else passes++;
        checks++; if (obsDoneRel != lastDRel + 3 + lastSpan) $display("[TB] FAIL restart_done_time: got %0d required %0d", obsDoneRel, lastDRel + 3 + lastSpan); else passes++;
        idle(2);
    endtask

    task automatic test_random();
        logic [15:0] eLag; logic [31:0] eMax; logic eErr;
        logic [15:0] tmin, tmax;
        int span, mode;
        for (int it = 0; it < 24; it++) begin
            tmin = 16'($urandom_range(0, 400)) - 16'd100;
            mode = int'($urandom_range(0, 5));
            if (mode == 0)      tmax = tmin - 16'($urandom_range(1, 20));
            else if (mode == 1) tmax = tmin + 16'($urandom_range(32, 60));
            else                tmax = tmin + 16'($urandom_range(0, 31));
            span = int'($signed(tmax)) - int'($signed(tmin));
            vals.delete();
            if (span >= 0 && span <= MAX_LAG_SPAN) begin
                for (int k = 0; k <= span; k++)
                    vals.push_back(($urandom_range(0, 3) == 0) ? 32'h0000_2000 : $urandom());
                load_corr();
            end
            ref_search(tmin, tmax, eLag, eMax, eErr);
            drive_search(tmin, tmax, 12'($urandom()), int'($urandom_range(0, 5)), 0);
            checks++; if (obsLag !== eLag || obsMax !== eMax || obsErr !== eErr) $display("[TB] FAIL rand%0d_result: got %0d/%h/%b required %0d/%h/%b", it, obsLag, obsMax, obsErr, eLag, eMax, eErr); else passes++;
            checks++; if (obsDoneRel != (eErr ? 2 : lastDRel + 3 + span)) $display("[TB] FAIL rand%0d_done_time: got %0d required %0d", it, obsDoneRel, eErr ? 2 : lastDRel + 3 + span); else passes++;
            checks++; if (obsTMin !== tmin - 16'(L_INTER4) || obsTMax !== tmax + 16'(L_INTER4)) $display("[TB] FAIL rand%0d_window: got %h/%h required %h/%h", it, obsTMin, obsTMax, tmin - 16'(L_INTER4), tmax + 16'(L_INTER4)); else passes++;
            if (!eErr) begin
                checks++; if (addr_errors(span) != 0) $display("[TB] FAIL rand%0d_addr: got %0d bad addresses required 0", it, addr_errors(span)); else passes++;
            end
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom();
        reset = 1'b1; start = 1'b0; normCorrDone = 1'b0;
        t0_min = '0; t0_max = '0; excAddr = '0;
        idle(3);
        reset = 1'b0;
        test_reset();
        test_peak_window();
        test_tie();
        test_negative_single();
        test_invalid_window();
        test_span_boundary();
        test_reset_in_wait();
        test_start_during_scan();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
